// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: ALU operation codes, flag type and divider FSM states.
package div_sequencer_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_operation_t;
  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} flag_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  function automatic logic is_div_op(input alu_operation_t op);
    return op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU;
  endfunction
  function automatic logic is_signed_op(input alu_operation_t op);
    return op == ALU_DIV || op == ALU_REM;
  endfunction
  function automatic logic is_rem_op(input alu_operation_t op);
    return op == ALU_REM || op == ALU_REMU;
  endfunction
endpackage

// File: rtl/div_core.sv
// div_core: one restoring-division step; remainder carries an extra bit so the
// trial subtraction sign is visible.
module div_core #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);
  logic [W+1:0] sh, df;
  assign sh    = {rem_i, quo_i[W-1]};
  assign df    = sh - {2'b00, dvs_i};
  assign rem_o = df[W+1] ? sh[W:0] : df[W:0];
  assign quo_o = {quo_i[W-2:0], ~df[W+1]};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU/REM/REMU sequencer with pipeline stall.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  alu_operation_t        op_sel_i,
  input  logic [DATA_WIDTH-1:0] bus_a_i,
  input  logic [DATA_WIDTH-1:0] bus_b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] out_o,
  output flag_t                 div_zero_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W:0] rem_q, rem_n;
  logic [W-1:0] quo_q, quo_n, dvs_q, fq_q, fr_q, out_q, abs_a, abs_b, min_v, c_q, c_r, res;
  logic sgn, a_neg, b_neg, is_zero, is_ovf, hit, accept, is_rem_q, neg_q_q, neg_r_q, dz_q;
  assign min_v   = {1'b1, {(W-1){1'b0}}};
  assign sgn     = is_signed_op(op_sel_i);
  assign a_neg   = sgn && bus_a_i[W-1];
  assign b_neg   = sgn && bus_b_i[W-1];
  assign abs_a   = a_neg ? -bus_a_i : bus_a_i;
  assign abs_b   = b_neg ? -bus_b_i : bus_b_i;
  assign is_zero = bus_b_i == '0;
  assign is_ovf  = sgn && bus_a_i == min_v && bus_b_i == '1;
  assign accept  = state_q == IDLE && start_i && is_div_op(op_sel_i) && !flush_i;
  div_core #(.W(W)) u_core (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else if (accept) state_d = (is_zero || is_ovf || hit) ? DONE : BUSY;
    else if (state_q == BUSY && cnt_q == '0) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  assign busy_o     = state_q != IDLE;
  assign stall_o    = (start_i && is_div_op(op_sel_i) && state_q == IDLE) || state_q == BUSY;
  assign done_o     = state_q == DONE && !flush_i;
  assign res        = is_rem_q ? fr_q : fq_q;
  assign out_o      = done_o ? res : out_q;
  assign div_zero_o = flag_t'(done_o && dz_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      fq_q     <= '0;
      fr_q     <= '0;
      out_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= CW'(W - 1);
        rem_q    <= '0;
        quo_q    <= abs_a;
        dvs_q    <= abs_b;
        is_rem_q <= is_rem_op(op_sel_i);
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= a_neg;
        dz_q     <= is_zero;
        fq_q     <= is_zero ? '1 : is_ovf ? min_v : c_q;
        fr_q     <= is_zero ? bus_a_i : is_ovf ? '0 : c_r;
      end else if (state_q == BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          fq_q <= neg_q_q ? -quo_n : quo_n;
          fr_q <= neg_r_q ? -rem_n[W-1:0] : rem_n[W-1:0];
        end
      end
      if (done_o) out_q <= res;
    end
`ifdef DIV_RESULT_CACHE_EN
  logic c_vld_q, c_sgn_q, k_sgn_q;
  logic [W-1:0] c_a_q, c_b_q, c_q_q, c_r_q, k_a_q, k_b_q;
  // Entry survives flush; only reset invalidates it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      k_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_q_q   <= '0;
      c_r_q   <= '0;
      k_a_q   <= '0;
      k_b_q   <= '0;
    end else begin
      if (accept) begin
        k_a_q   <= bus_a_i;
        k_b_q   <= bus_b_i;
        k_sgn_q <= sgn;
      end
      if (state_q == DONE) begin
        c_vld_q <= 1'b1;
        c_a_q   <= k_a_q;
        c_b_q   <= k_b_q;
        c_sgn_q <= k_sgn_q;
        c_q_q   <= fq_q;
        c_r_q   <= fr_q;
      end
    end
  assign hit = c_vld_q && c_a_q == bus_a_i && c_b_q == bus_b_i && c_sgn_q == sgn;
  assign c_q = c_q_q;
  assign c_r = c_r_q;
`else
  assign hit = 1'b0;
  assign c_q = '0;
  assign c_r = '0;
`endif
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of the divide sequencer.
module tb_div_sequencer;
  import div_sequencer_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, flush_i = 1'b0;
  alu_operation_t op_sel_i = ALU_ADD;
  logic [31:0] bus_a_i = '0, bus_b_i = '0, out_o;
  logic busy_o, stall_o, done_o;
  flag_t div_zero_o;
  int total = 0, bad = 0, seen;
`ifdef DIV_RESULT_CACHE_EN
  localparam int REP = 1;
`else
  localparam int REP = 33;
`endif
  div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_sel_i(op_sel_i),
    .bus_a_i(bus_a_i), .bus_b_i(bus_b_i), .flush_i(flush_i), .busy_o(busy_o),
    .stall_o(stall_o), .done_o(done_o), .out_o(out_o), .div_zero_o(div_zero_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input alu_operation_t op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                     input logic dz_exp);
    int lat = 0;
    op_sel_i = op;
    bus_a_i  = a;
    bus_b_i  = b;
    start_i  = 1'b1;
    #0 chk({tag, "_stall_t0"}, stall_o, 1);
    while (!done_o && lat < 100) begin
      step();
      lat++;
      start_i = 1'b0;
      if (!done_o) chk({tag, "_stall_busy"}, stall_o, 1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_out"}, out_o, exp);
    chk({tag, "_divzero"}, div_zero_o, dz_exp);
    chk({tag, "_stall_done"}, stall_o, 0);
    step();
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_held"}, out_o, exp);
  endtask
  initial begin
    repeat (2) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_out", out_o, 0);
    chk("rst_dz", div_zero_o, 0);
    rst_n = 1'b1;
    step();
    run("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, REP, 1'b0);
    run("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, REP, 1'b0);
    run("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, REP, 1'b0);
    run("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
    op_sel_i = ALU_DIVU;
    bus_a_i  = 32'd1000;
    bus_b_i  = 32'd3;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    chk("flush_busy_before", busy_o, 1);
    flush_i = 1'b1;
    #0 chk("flush_no_done", done_o, 0);
    step();
    flush_i = 1'b0;
    chk("flush_idle", busy_o, 0);
    chk("flush_stall", stall_o, 0);
    chk("flush_out_kept", out_o, 32'hFFFF_FFFF);
    seen = 0;
    repeat (40) begin
      step();
      if (done_o) seen++;
    end
    chk("flush_no_pulse", 32'(seen), 0);
    op_sel_i = ALU_ADD;
    start_i  = 1'b1;
    #0 chk("nondiv_stall", stall_o, 0);
    step();
    start_i = 1'b0;
    chk("nondiv_idle", busy_o, 0);
    op_sel_i = ALU_DIVU;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    repeat (5) step();
    chk("midrst_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_stall", stall_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_out", out_o, 0);
    chk("midrst_dz", div_zero_o, 0);
    step();
    rst_n = 1'b1;
    step();
    run("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
